// File: rtl/data_sram_responder.sv
// Responder end of the data_sram interface. It holds a word-organised data memory,
// inserts WAIT_CYCLES stall cycles per access, and checks alignment when DSRAM_ALIGN_CHECK_EN is defined.
module data_sram_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        resp_valid,
  output logic        stallreq_for_mem,
  output logic        busy,
  output logic        align_err
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam int         DEPTH     = 2 ** ADDR_W;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t            state;
  logic [3:0]        cnt;
  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              complete;
  logic              wen_legal;
  logic              do_write;
  logic              unused_addr;

  assign idx         = data_sram_addr[ADDR_W+1:2];
  assign unused_addr = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

  // The access completes on the edge that ends its last cycle. With no wait states
  // that is the request cycle itself.
  assign complete = data_sram_en &&
                    ((state == IDLE && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd0));

  assign stallreq_for_mem = data_sram_en &&
                            ((state == IDLE && WAIT_CYCLES != 0) || (state == WAIT && cnt != 4'd0));
  assign busy = (state == WAIT);

`ifdef DSRAM_ALIGN_CHECK_EN
  function automatic logic wen_is_legal(input logic [3:0] w, input logic [1:0] a);
    case (w)
      4'b0000: return 1'b1;
      4'b0001: return a == 2'b00;
      4'b0010: return a == 2'b01;
      4'b0100: return a == 2'b10;
      4'b1000: return a == 2'b11;
      4'b0011: return a == 2'b00;
      4'b1100: return a == 2'b10;
      4'b1111: return a == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  assign wen_legal = wen_is_legal(data_sram_wen, data_sram_addr[1:0]);

  always_ff @(posedge clk) begin
    if (rst) align_err <= 1'b0;
    else     align_err <= complete && !wen_legal;
  end
`else
  assign wen_legal = 1'b1;
  assign align_err = 1'b0;
`endif

  assign do_write = complete && (data_sram_wen != 4'b0000) && wen_legal && !rst;

  // NOTE: the memory array is deliberately left out of reset so it can map onto a RAM macro.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wen[b]) mem[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

  // NOTE: all state updates use non-blocking assignment, so the read samples pre-edge contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= 4'd0;
      data_sram_rdata <= 32'd0;
      resp_valid      <= 1'b0;
    end else begin
      resp_valid <= complete;
      if (complete && data_sram_wen == 4'b0000) data_sram_rdata <= mem[idx];
      case (state)
        IDLE: begin
          if (data_sram_en && WAIT_CYCLES != 0) begin
            state <= WAIT;
            cnt   <= WAIT_INIT;
          end
        end
        WAIT: begin
          if (!data_sram_en) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else if (cnt == 4'd0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder: three instances with 0, 3 and 2 wait states.
// Expected responses are queued when an access is issued and compared when resp_valid appears.
module tb_data_sram_responder;

`ifdef DSRAM_ALIGN_CHECK_EN
  localparam logic ALIGN_ON = 1'b1;
`else
  localparam logic ALIGN_ON = 1'b0;
`endif

  typedef struct {
    int          k;
    logic        is_read;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst       [3];
  logic        en        [3];
  logic [3:0]  wen       [3];
  logic [31:0] addr      [3];
  logic [31:0] wdata     [3];
  logic [31:0] rdata     [3];
  logic        resp_valid[3];
  logic        stallreq  [3];
  logic        busy      [3];
  logic        align_err [3];

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  data_sram_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .data_sram_en(en[0]), .data_sram_wen(wen[0]),
    .data_sram_addr(addr[0]), .data_sram_wdata(wdata[0]), .data_sram_rdata(rdata[0]),
    .resp_valid(resp_valid[0]), .stallreq_for_mem(stallreq[0]), .busy(busy[0]),
    .align_err(align_err[0]));

  data_sram_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .rst(rst[1]), .data_sram_en(en[1]), .data_sram_wen(wen[1]),
    .data_sram_addr(addr[1]), .data_sram_wdata(wdata[1]), .data_sram_rdata(rdata[1]),
    .resp_valid(resp_valid[1]), .stallreq_for_mem(stallreq[1]), .busy(busy[1]),
    .align_err(align_err[1]));

  data_sram_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst[2]), .data_sram_en(en[2]), .data_sram_wen(wen[2]),
    .data_sram_addr(addr[2]), .data_sram_wdata(wdata[2]), .data_sram_rdata(rdata[2]),
    .resp_valid(resp_valid[2]), .stallreq_for_mem(stallreq[2]), .busy(busy[2]),
    .align_err(align_err[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int wait_of(input int k);
    case (k)
      1:       return 3;
      2:       return 2;
      default: return 0;
    endcase
  endfunction

  // Compares each response pulse against the oldest queued expectation.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (resp_valid[k]) begin
        if (sb_q.size() == 0 || sb_q[0].k != k) begin
          check($sformatf("spurious_resp_dut%0d", k), 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if (e.is_read) check($sformatf("rdata_dut%0d", k), rdata[k], e.rdata);
          check($sformatf("align_err_dut%0d", k), {31'd0, align_err[k]}, {31'd0, e.err});
        end
      end else if (align_err[k]) begin
        check($sformatf("align_err_without_resp_dut%0d", k), 32'd1, 32'd0);
      end
    end
  end

  // Issues one access with inputs held stable until completion; checks stall/busy counts.
  task automatic access(input int k, input logic [3:0] w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
    int   stalls = 0;
    int   busys  = 0;
    logic done   = 1'b0;
    exp_t e;
    en[k] = 1'b1; wen[k] = w; addr[k] = a; wdata[k] = d;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (stallreq[k]) stalls++;
      if (busy[k]) busys++;
      if (!stallreq[k]) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check($sformatf("complete_dut%0d_a%h", k, a), {31'd0, done}, 32'd1);
    e.k = k; e.is_read = (w == 4'b0000); e.rdata = exp_rd; e.err = exp_err;
    sb_q.push_back(e);
    check($sformatf("stalls_dut%0d_a%h", k, a), stalls, wait_of(k));
    check($sformatf("busy_cycles_dut%0d_a%h", k, a), busys, wait_of(k));
    @(posedge clk); #1;
    en[k] = 1'b0; wen[k] = 4'b0000;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; en[k] = 1'b0; wen[k] = 4'b0000; addr[k] = 32'd0; wdata[k] = 32'd0;
    end
    idle_cycles(3);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_rdata_dut%0d", k), rdata[k], 32'd0);
      check($sformatf("reset_resp_dut%0d", k), {31'd0, resp_valid[k]}, 32'd0);
      check($sformatf("reset_busy_dut%0d", k), {31'd0, busy[k]}, 32'd0);
      check($sformatf("reset_stall_dut%0d", k), {31'd0, stallreq[k]}, 32'd0);
      check($sformatf("reset_align_dut%0d", k), {31'd0, align_err[k]}, 32'd0);
    end
    @(posedge clk); #1;

    // Zero wait states: back-to-back write then read, byte write, address aliasing.
    access(0, 4'b1111, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    access(0, 4'b0000, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    access(0, 4'b1111, 32'h20, 32'h00000000, 32'h0, 1'b0);
    access(0, 4'b0100, 32'h22, 32'h5A5A5A5A, 32'h0, 1'b0);
    access(0, 4'b0000, 32'h20, 32'h0, 32'h005A0000, 1'b0);
    access(0, 4'b1000, 32'h23, 32'hC3C3C3C3, 32'h0, 1'b0);
    access(0, 4'b0000, 32'h20, 32'h0, 32'hC35A0000, 1'b0);
    access(0, 4'b0000, 32'h13, 32'h0, 32'hDEADBEEF, 1'b0);
    access(0, 4'b0000, 32'h00001010, 32'h0, 32'hDEADBEEF, 1'b0);
    access(0, 4'b1111, 32'h40, 32'h01234567, 32'h0, 1'b0);
    access(0, 4'b1111, 32'h41, 32'hFFFFFFFF, 32'h0, ALIGN_ON);
    access(0, 4'b0000, 32'h40, 32'h0, ALIGN_ON ? 32'h01234567 : 32'hFFFFFFFF, 1'b0);
    access(0, 4'b1111, 32'h20, 32'h77777777, 32'h0, 1'b0);
    idle_cycles(1);
    @(negedge clk);
    check("rdata_hold_after_write", rdata[0], ALIGN_ON ? 32'h01234567 : 32'hFFFFFFFF);
    @(posedge clk); #1;

    // Three wait states: stalled write/read, then an aborted write.
    access(1, 4'b1111, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    access(1, 4'b0000, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    access(1, 4'b1111, 32'h30, 32'h00000000, 32'h0, 1'b0);
    en[1] = 1'b1; wen[1] = 4'b1111; addr[1] = 32'h30; wdata[1] = 32'h11111111;
    @(negedge clk);
    check("abort_first_stall", {31'd0, stallreq[1]}, 32'd1);
    @(posedge clk); #1;
    en[1] = 1'b0; wen[1] = 4'b0000;
    @(negedge clk);
    check("abort_stall_dropped", {31'd0, stallreq[1]}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_back_idle", {31'd0, busy[1]}, 32'd0);
    idle_cycles(4);
    access(1, 4'b0000, 32'h30, 32'h0, 32'h00000000, 1'b0);

    // Two wait states: reset during the second stall cycle drops the pending write.
    access(2, 4'b1111, 32'h50, 32'hCAFEF00D, 32'h0, 1'b0);
    access(2, 4'b0000, 32'h50, 32'h0, 32'hCAFEF00D, 1'b0);
    en[2] = 1'b1; wen[2] = 4'b1111; addr[2] = 32'h50; wdata[2] = 32'h12345678;
    @(negedge clk);
    check("rst_first_stall", {31'd0, stallreq[2]}, 32'd1);
    @(posedge clk); #1;
    rst[2] = 1'b1;
    @(negedge clk);
    check("rst_in_wait_busy", {31'd0, busy[2]}, 32'd1);
    @(posedge clk); #1;
    rst[2] = 1'b0; en[2] = 1'b0; wen[2] = 4'b0000;
    @(negedge clk);
    check("rst_busy", {31'd0, busy[2]}, 32'd0);
    check("rst_stall", {31'd0, stallreq[2]}, 32'd0);
    check("rst_rdata", rdata[2], 32'd0);
    check("rst_resp", {31'd0, resp_valid[2]}, 32'd0);
    @(posedge clk); #1;
    idle_cycles(2);
    access(2, 4'b0000, 32'h50, 32'h0, 32'hCAFEF00D, 1'b0);

    idle_cycles(3);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
